// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-port cache-line memory arbiter: FSM states, default
// widths and the port-select encoding used by the winner picker.
package mem_arbiter_pkg;

   localparam int ADDR_W_DEF = 28;
   localparam int LINE_W_DEF = 128;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_I = 2'd1,
      GRANT_D = 2'd2
   } arb_state_e;

   localparam logic PORT_I = 1'b0;
   localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational winner selection between the I and D request lines.
// ARB_ROUND_ROBIN_EN: ties go to the port that lost last time; otherwise D wins.
module arb_pick
   import mem_arbiter_pkg::*;
(
   input  logic req_i,
   input  logic req_d,
`ifdef ARB_ROUND_ROBIN_EN
   input  logic last,
`endif
   output logic pick
);

   always_comb begin
      pick = PORT_D;
      if (req_i && !req_d) begin
         pick = PORT_I;
      end else if (req_i && req_d) begin
`ifdef ARB_ROUND_ROBIN_EN
         pick = ~last;
`else
         pick = PORT_D;
`endif
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache and D-cache line requests onto one slow memory port.
// Build option ARB_ROUND_ROBIN_EN selects round-robin tie breaking (default: D wins).
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int LINE_W = LINE_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_read,
   input  logic              i_write,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [LINE_W-1:0] i_wdata,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_ready,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_ready,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic [LINE_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output arb_state_e        state
);

   // Handshake: a cache holds read/write as a level until its ready pulses for
   // one cycle; memory sees mem_read/mem_write held until its one-cycle
   // mem_ready, which is forwarded combinationally to the granted cache only.

   arb_state_e        state_q, state_d;
   logic              pend_i, pend_d, grant, pick;
   logic              sel_read, sel_write;
   logic [ADDR_W-1:0] sel_addr;
   logic [LINE_W-1:0] sel_wdata;

   assign pend_i = i_read | i_write;
   assign pend_d = d_read | d_write;
   assign grant  = (state_q == IDLE) && (pend_i || pend_d);

`ifdef ARB_ROUND_ROBIN_EN
   logic last_win;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)        last_win <= PORT_I;
      else if (grant) last_win <= pick;
   end

   arb_pick u_pick (.req_i(pend_i), .req_d(pend_d), .last(last_win), .pick(pick));
`else
   arb_pick u_pick (.req_i(pend_i), .req_d(pend_d), .pick(pick));
`endif

   always_comb begin
      sel_read  = i_read;
      sel_write = i_write;
      sel_addr  = i_addr;
      sel_wdata = i_wdata;
      if (pick == PORT_D) begin
         sel_read  = d_read;
         sel_write = d_write;
         sel_addr  = d_addr;
         sel_wdata = d_wdata;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:             if (grant) state_d = (pick == PORT_D) ? GRANT_D : GRANT_I;
         GRANT_I, GRANT_D: if (mem_ready) state_d = IDLE;
         default:          state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // A combined read+write is forwarded as a write only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else if (grant) begin
         mem_read  <= sel_read & ~sel_write;
         mem_write <= sel_write;
         mem_addr  <= sel_addr;
         mem_wdata <= sel_wdata;
      end else if ((state_q != IDLE) && mem_ready) begin
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
      end
   end

   assign i_ready = (state_q == GRANT_I) && mem_ready;
   assign d_ready = (state_q == GRANT_D) && mem_ready;
   assign i_rdata = i_ready ? mem_rdata : '0;
   assign d_rdata = d_ready ? mem_rdata : '0;
   assign state   = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed cycle table, tie-order sequence, and randomized
// traffic checked against a transaction-level arbitration and memory model.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   localparam int AW = 28;
   localparam int LW = 128;
   localparam logic [LW-1:0] DEAD = 128'hDEADBEEF_01234567_89ABCDEF_0BADF00D;
   localparam logic [LW-1:0] IWD  = 128'h11111111_22222222_33333333_44444444;
   localparam logic [LW-1:0] DWD  = 128'h55555555_66666666_77777777_88888888;

   // ---------------- clock / reset / DUT ----------------
   logic          clk = 1'b0;
   logic          rst;
   logic          i_read, i_write, i_ready;
   logic [AW-1:0] i_addr;
   logic [LW-1:0] i_wdata, i_rdata;
   logic          d_read, d_write, d_ready;
   logic [AW-1:0] d_addr;
   logic [LW-1:0] d_wdata, d_rdata;
   logic          mem_read, mem_write, mem_ready;
   logic [AW-1:0] mem_addr;
   logic [LW-1:0] mem_wdata, mem_rdata;
   arb_state_e    dut_state;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
      .clk(clk), .rst(rst),
      .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
      .i_rdata(i_rdata), .i_ready(i_ready),
      .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ready(d_ready),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .state(dut_state)
   );

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_vec++;
      n_bad++;
      $display("FAIL %s: condition not met within bound", name);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic          rst, ir, iw, dr, dw, mr;
      logic [AW-1:0] ia, da;
      arb_state_e    e_st;
      logic          e_mrd, e_mwr, chk_a, e_ir, e_dr;
      logic [AW-1:0] e_addr;
      int            e_ws;  // 0: unchecked, 1: I wdata, 2: D wdata, 3: zero
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t v(input logic r, ir, iw, input int ia, input logic dr, dw,
                              input int da, input logic mr, input arb_state_e st,
                              input logic mrd, mwr, input int ea, input int ws,
                              input logic eir, edr);
      vec_t t;
      t.rst = r;  t.ir = ir;  t.iw = iw;  t.ia = AW'(ia);
      t.dr = dr;  t.dw = dw;  t.da = AW'(da);  t.mr = mr;
      t.e_st = st;  t.e_mrd = mrd;  t.e_mwr = mwr;
      t.chk_a = (ea >= 0);  t.e_addr = (ea >= 0) ? AW'(ea) : '0;
      t.e_ws = ws;  t.e_ir = eir;  t.e_dr = edr;
      return t;
   endfunction

   // ---------------- memory environment and scoreboard ----------------
   typedef struct {
      logic          rd, wr, drop;
      logic [AW-1:0] a;
      logic [LW-1:0] d;
   } txn_t;

   typedef struct packed {
      logic          port;
      logic          wr;
      logic [AW-1:0] a;
      logic [LW-1:0] d;
   } exp_t;

   exp_t          exp_q[$];
   txn_t          iq[$], dq[$];
   logic          done_ports[$];
   logic [LW-1:0] sim_mem[int];
   logic [LW-1:0] ref_mem[int];
   int            lat_cnt = -1;
   bit            rand_mode = 1'b0;

   function automatic logic [LW-1:0] def_line(input int a);
      return {4{32'hC0DE_0000 ^ 32'(a)}};
   endfunction

   task automatic present_i();
      if (iq.size() > 0) begin
         i_read = iq[0].rd;  i_write = iq[0].wr;  i_addr = iq[0].a;  i_wdata = iq[0].d;
      end else begin
         i_read = 1'b0;  i_write = 1'b0;
      end
   endtask

   task automatic present_d();
      if (dq.size() > 0) begin
         d_read = dq[0].rd;  d_write = dq[0].wr;  d_addr = dq[0].a;  d_wdata = dq[0].d;
      end else begin
         d_read = 1'b0;  d_write = 1'b0;
      end
   endtask

   task automatic handle_done();
      logic          port;
      logic [LW-1:0] got;
      exp_t          e;
      port = d_ready ? PORT_D : PORT_I;
      done_ports.push_back(port);
      if (!rand_mode) return;
      if (exp_q.size() == 0) begin
         fail_now("unexpected_completion");
         return;
      end
      e = exp_q.pop_front();
      got = (port == PORT_D) ? d_rdata : i_rdata;
      check("done_port", LW'(port), LW'(e.port));
      check("done_mem_write", LW'(mem_write), LW'(e.wr));
      check("done_mem_read", LW'(mem_read), LW'(!e.wr));
      check("done_mem_addr", LW'(mem_addr), LW'(e.a));
      if (e.wr) check("done_mem_wdata", mem_wdata, e.d);
      else      check("done_rdata", got, e.d);
      if (port == PORT_D) begin
         if (dq.size() > 0) void'(dq.pop_front());
         present_d();
      end else begin
         if (iq.size() > 0) void'(iq.pop_front());
         present_i();
      end
   endtask

   // One clock: advance the memory responder, then check and react to the DUT.
   task automatic cycle();
      @(posedge clk);
      #1;
      if (mem_ready) begin
         mem_ready = 1'b0;
      end else if (mem_read || mem_write) begin
         if (lat_cnt < 0) lat_cnt = $urandom_range(0, 3);
         if (lat_cnt == 0) begin
            lat_cnt = -1;
            mem_ready = 1'b1;
            if (mem_write) sim_mem[int'(mem_addr)] = mem_wdata;
         end else begin
            lat_cnt--;
         end
      end
      if (mem_ready && mem_read)
         mem_rdata = sim_mem.exists(int'(mem_addr)) ? sim_mem[int'(mem_addr)] : def_line(int'(mem_addr));
      else
         mem_rdata = {4{$urandom}};
      #1;
      check("ready_exclusive", LW'(i_ready & d_ready), '0);
      if (!i_ready) check("i_rdata_idle", i_rdata, '0);
      if (!d_ready) check("d_rdata_idle", d_rdata, '0);
      if (rand_mode) begin
         if (dut_state == GRANT_I && !i_ready && iq.size() > 0 && iq[0].drop) begin
            i_read = 1'b0;  i_write = 1'b0;  i_addr = AW'($urandom);
         end
         if (dut_state == GRANT_D && !d_ready && dq.size() > 0 && dq[0].drop) begin
            d_read = 1'b0;  d_write = 1'b0;  d_addr = AW'($urandom);
         end
      end
      if (i_ready || d_ready) handle_done();
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      i_read = 1'b0;  i_write = 1'b0;  d_read = 1'b0;  d_write = 1'b0;
      mem_ready = 1'b0;
      lat_cnt = -1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Transaction-level model: both ports always have their next request
   // waiting, so each decision is a tie while both queues are non-empty.
   task automatic build_expect();
      int   ii = 0;
      int   di = 0;
      logic last = PORT_I;
      logic win;
      txn_t t;
      exp_t e;
      while (ii < iq.size() || di < dq.size()) begin
         if (ii < iq.size() && di < dq.size()) begin
`ifdef ARB_ROUND_ROBIN_EN
            win = ~last;
`else
            win = PORT_D;
`endif
         end else begin
            win = (di < dq.size()) ? PORT_D : PORT_I;
         end
         last = win;
         if (win == PORT_D) t = dq[di++];
         else               t = iq[ii++];
         e.port = win;  e.wr = t.wr;  e.a = t.a;
         if (t.wr) begin
            e.d = t.d;
            ref_mem[int'(t.a)] = t.d;
         end else begin
            e.d = ref_mem.exists(int'(t.a)) ? ref_mem[int'(t.a)] : def_line(int'(t.a));
         end
         exp_q.push_back(e);
      end
   endtask

   function automatic txn_t rand_txn();
      txn_t t;
      int   op;
      op = $urandom_range(0, 2);
      t.rd = (op != 1);
      t.wr = (op != 0);
      t.a = AW'($urandom_range(0, 7));
      t.d = {4{$urandom}};
      t.drop = ($urandom_range(0, 3) == 0);
      return t;
   endfunction

   task automatic rand_round(input int ni, input int nd);
      pulse_reset();
      iq.delete();  dq.delete();  exp_q.delete();  done_ports.delete();
      for (int k = 0; k < ni; k++) iq.push_back(rand_txn());
      for (int k = 0; k < nd; k++) dq.push_back(rand_txn());
      build_expect();
      rand_mode = 1'b1;
      present_i();
      present_d();
      for (int k = 0; k < 3000 && exp_q.size() > 0; k++) cycle();
      if (exp_q.size() > 0) fail_now("random_round_timeout");
      rand_mode = 1'b0;
      iq.delete();  dq.delete();
      present_i();
      present_d();
      repeat (4) cycle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $fatal(1, "watchdog");
   end

   // ---------------- test sequence ----------------
   initial begin
      logic [1:0] exp_port;
      rst = 1'b1;
      i_read = 1'b0;  i_write = 1'b0;  i_addr = '0;  i_wdata = IWD;
      d_read = 1'b0;  d_write = 1'b0;  d_addr = '0;  d_wdata = DWD;
      mem_ready = 1'b0;  mem_rdata = '0;
      repeat (2) @(posedge clk);
      #1;
      mem_ready = 1'b1;
      mem_rdata = DEAD;
      #1;
      check("reset_state", LW'(dut_state), LW'(IDLE));
      check("reset_mem_read", LW'(mem_read), '0);
      check("reset_mem_write", LW'(mem_write), '0);
      check("reset_mem_addr", LW'(mem_addr), '0);
      check("reset_mem_wdata", mem_wdata, '0);
      check("reset_i_ready", LW'(i_ready), '0);
      check("reset_d_ready", LW'(d_ready), '0);
      check("reset_i_rdata", i_rdata, '0);
      check("reset_d_rdata", d_rdata, '0);
      mem_ready = 1'b0;
      rst = 1'b0;

      // single I read, then D write vs I read tie
      vecs.push_back(v(0,1,0,'h10,0,0,0,0,     IDLE,   0,0,-1,  0,0,0));
      vecs.push_back(v(0,1,0,'h10,0,0,0,0,     GRANT_I,1,0,'h10,0,0,0));
      vecs.push_back(v(0,1,0,'h10,0,0,0,1,     GRANT_I,1,0,'h10,0,1,0));
      vecs.push_back(v(0,0,0,'h10,0,0,0,0,     IDLE,   0,0,-1,  0,0,0));
      vecs.push_back(v(0,1,0,'h10,0,1,'h20,0,  IDLE,   0,0,-1,  0,0,0));
      vecs.push_back(v(0,1,0,'h10,0,1,'h20,0,  GRANT_D,0,1,'h20,2,0,0));
      vecs.push_back(v(0,1,0,'h10,0,1,'h20,1,  GRANT_D,0,1,'h20,2,0,1));
      vecs.push_back(v(0,1,0,'h10,0,0,'h20,0,  IDLE,   0,0,-1,  0,0,0));
      vecs.push_back(v(0,1,0,'h10,0,0,0,0,     GRANT_I,1,0,'h10,0,0,0));
      vecs.push_back(v(0,1,0,'h10,0,0,0,1,     GRANT_I,1,0,'h10,0,1,0));
      vecs.push_back(v(0,0,0,0,0,0,0,0,        IDLE,   0,0,-1,  0,0,0));
      // read and write together -> write
      vecs.push_back(v(0,1,1,'h30,0,0,0,0,     IDLE,   0,0,-1,  0,0,0));
      vecs.push_back(v(0,1,1,'h30,0,0,0,0,     GRANT_I,0,1,'h30,1,0,0));
      vecs.push_back(v(0,1,1,'h30,0,0,0,1,     GRANT_I,0,1,'h30,1,1,0));
      vecs.push_back(v(0,0,0,0,0,0,0,0,        IDLE,   0,0,-1,  0,0,0));
      // request dropped after grant, address changed underneath
      vecs.push_back(v(0,1,0,'h40,0,0,0,0,     IDLE,   0,0,-1,  0,0,0));
      vecs.push_back(v(0,0,0,'h50,0,0,0,0,     GRANT_I,1,0,'h40,0,0,0));
      vecs.push_back(v(0,0,0,'h50,0,0,0,0,     GRANT_I,1,0,'h40,0,0,0));
      vecs.push_back(v(0,0,0,'h50,0,0,0,1,     GRANT_I,1,0,'h40,0,1,0));
      vecs.push_back(v(0,0,0,0,0,0,0,0,        IDLE,   0,0,-1,  0,0,0));
      vecs.push_back(v(0,0,0,0,0,0,0,1,        IDLE,   0,0,-1,  0,0,0));
      // reset in the middle of a D grant, then reissue
      vecs.push_back(v(0,0,0,0,1,0,'h60,0,     IDLE,   0,0,-1,  0,0,0));
      vecs.push_back(v(0,0,0,0,1,0,'h60,0,     GRANT_D,1,0,'h60,0,0,0));
      vecs.push_back(v(0,0,0,0,1,0,'h60,0,     GRANT_D,1,0,'h60,0,0,0));
      vecs.push_back(v(1,0,0,0,1,0,'h60,1,     IDLE,   0,0,0,   3,0,0));
      vecs.push_back(v(0,0,0,0,1,0,'h60,0,     IDLE,   0,0,0,   3,0,0));
      vecs.push_back(v(0,0,0,0,1,0,'h60,0,     GRANT_D,1,0,'h60,0,0,0));
      vecs.push_back(v(0,0,0,0,1,0,'h60,1,     GRANT_D,1,0,'h60,0,0,1));
      vecs.push_back(v(0,0,0,0,0,0,0,0,        IDLE,   0,0,-1,  0,0,0));

      foreach (vecs[k]) begin
         rst = vecs[k].rst;
         i_read = vecs[k].ir;  i_write = vecs[k].iw;  i_addr = vecs[k].ia;
         d_read = vecs[k].dr;  d_write = vecs[k].dw;  d_addr = vecs[k].da;
         mem_ready = vecs[k].mr;
         mem_rdata = vecs[k].mr ? DEAD : {4{$urandom}};
         #1;
         check($sformatf("row%0d_state", k), LW'(dut_state), LW'(vecs[k].e_st));
         check($sformatf("row%0d_mem_read", k), LW'(mem_read), LW'(vecs[k].e_mrd));
         check($sformatf("row%0d_mem_write", k), LW'(mem_write), LW'(vecs[k].e_mwr));
         check($sformatf("row%0d_i_ready", k), LW'(i_ready), LW'(vecs[k].e_ir));
         check($sformatf("row%0d_d_ready", k), LW'(d_ready), LW'(vecs[k].e_dr));
         check($sformatf("row%0d_i_rdata", k), i_rdata, vecs[k].e_ir ? DEAD : '0);
         check($sformatf("row%0d_d_rdata", k), d_rdata, vecs[k].e_dr ? DEAD : '0);
         if (vecs[k].chk_a)
            check($sformatf("row%0d_mem_addr", k), LW'(mem_addr), LW'(vecs[k].e_addr));
         if (vecs[k].e_ws == 1) check($sformatf("row%0d_mem_wdata", k), mem_wdata, IWD);
         if (vecs[k].e_ws == 2) check($sformatf("row%0d_mem_wdata", k), mem_wdata, DWD);
         if (vecs[k].e_ws == 3) check($sformatf("row%0d_mem_wdata", k), mem_wdata, '0);
         @(posedge clk);
         #1;
      end
      rst = 1'b0;

      // both ports held continuously: grant order over four completions
      pulse_reset();
      done_ports.delete();
      i_read = 1'b1;  i_addr = AW'('h10);
      d_read = 1'b1;  d_addr = AW'('h20);
      for (int k = 0; k < 80 && done_ports.size() < 4; k++) cycle();
      if (done_ports.size() < 4) fail_now("tie_order_timeout");
      for (int k = 0; k < 4 && k < done_ports.size(); k++) begin
`ifdef ARB_ROUND_ROBIN_EN
         exp_port = (k % 2 == 0) ? 2'(PORT_D) : 2'(PORT_I);
`else
         exp_port = 2'(PORT_D);
`endif
         check($sformatf("tie_order_%0d", k), LW'(done_ports[k]), LW'(exp_port));
      end
      i_read = 1'b0;
      d_read = 1'b0;
      repeat (8) cycle();

      // randomized traffic: contended, D only, I only, contended again
      rand_round(10, 10);
      rand_round(0, 6);
      rand_round(6, 0);
      rand_round($urandom_range(4, 12), $urandom_range(4, 12));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
